// File: rtl/axis_bram_adapter_pkg.sv
// axis_bram_adapter_pkg: shared FSM encoding and counter sizing for the adapter scheduler
package axis_bram_adapter_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int CNT_EXTRA = 6;
  localparam logic IDLE_RW = 1'b1;
  function automatic int cnt_w(input int addr_len);
    return addr_len + CNT_EXTRA;
  endfunction
endpackage

// File: rtl/axis_bram_adapter_v1_0_rr_arb.sv
// axis_bram_adapter_v1_0_rr_arb: round-robin arbiter, search starts one past the last grant
module axis_bram_adapter_v1_0_rr_arb #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] last;
  // walk from lowest to highest priority so the highest-priority request is assigned last
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[IW'((int'(last) + 1 + k) % N)]) idx = IW'((int'(last) + 1 + k) % N);
  end
  assign any = |req;
  assign grant = any ? N'(1) << idx : '0;
  always_ff @(posedge clk)
    if (rst) last <= IW'(N - 1);
    else if (adv && any) last <= idx;
endmodule

// File: rtl/axis_bram_adapter_v1_0_sched.sv
// axis_bram_adapter_v1_0_sched: shares one adapter controller between requesters, one transfer at a time
module axis_bram_adapter_v1_0_sched
  import axis_bram_adapter_pkg::*;
#(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int NUM_REQ            = 2,
  parameter int DRAIN_CYCLES       = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0]                   req_rw,
  input  logic [NUM_REQ*BRAM_ADDR_LENGTH-1:0]  req_start,
  input  logic [NUM_REQ*BRAM_ADDR_LENGTH-1:0]  req_bound,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic [NUM_REQ-1:0]                   req_err,
  output logic                                 busy,
  output logic                                 cntl_rw,
  output logic                                 cntl_addr_reload,
  output logic [BRAM_ADDR_LENGTH-1:0]          cntl_start_index,
  output logic [BRAM_ADDR_LENGTH-1:0]          cntl_bound_index,
  output logic                                 in_gate,
  output logic                                 out_gate,
  input  logic                                 s_in_valid,
  input  logic                                 s_in_accep,
  input  logic                                 s_out_valid,
  input  logic                                 s_out_accep,
  input  logic                                 s_out_tlast
);
  localparam int L  = BRAM_ADDR_LENGTH;
  localparam int CW = cnt_w(L);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t state;
  logic [NUM_REQ-1:0] grant, gnt_oh;
  logic [IW-1:0] idx;
  logic any, grant_now, bad, sel_rw, beat, rd_last;
  logic [L-1:0] sel_start, sel_bound;
  logic [CW-1:0] cnt, target;
  logic [DW-1:0] dcnt;
  axis_bram_adapter_v1_0_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .adv(grant_now),
    .grant(grant), .idx(idx), .any(any)
  );
  always_comb begin
    sel_start = '0;
    sel_bound = '0;
    sel_rw = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (idx == IW'(i)) begin
        sel_start = req_start[i*L +: L];
        sel_bound = req_bound[i*L +: L];
        sel_rw = req_rw[i];
      end
  end
  assign bad = sel_bound < sel_start;
  assign grant_now = state == S_IDLE && any;
  assign req_ready = grant_now ? grant : '0;
  assign req_err = grant_now && bad ? grant : '0;
  assign beat = s_in_valid & s_in_accep & in_gate;
  assign rd_last = s_out_valid & s_out_accep & s_out_tlast & out_gate;
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      cntl_rw <= IDLE_RW;
      cntl_addr_reload <= 1'b0;
      cntl_start_index <= '0;
      cntl_bound_index <= '0;
      in_gate <= 1'b0;
      out_gate <= 1'b0;
      req_done <= '0;
      gnt_oh <= '0;
      cnt <= '0;
      target <= '0;
      dcnt <= '0;
    end else
      case (state)
        S_IDLE: if (any && !bad) begin
          state <= S_LOAD;
          gnt_oh <= grant;
          cntl_rw <= sel_rw;
          cntl_start_index <= sel_start;
          cntl_bound_index <= sel_bound;
          cntl_addr_reload <= 1'b1;
          busy <= 1'b1;
        end
        S_LOAD: begin
          // widened before subtracting so a full 2^L-row span cannot wrap
          target <= (CW'(cntl_bound_index) - CW'(cntl_start_index) + CW'(1)) * CW'(BRAM_WIDTH_IN_WORD);
          cntl_addr_reload <= 1'b0;
          cnt <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          in_gate <= cntl_rw;
          out_gate <= !cntl_rw;
          state <= S_RUN;
        end
        S_RUN:
          if (cntl_rw) begin
            if (beat) begin
              cnt <= cnt + CW'(1);
              if (cnt + CW'(1) == target) begin
                in_gate <= 1'b0;
                dcnt <= '0;
                state <= S_DRAIN;
              end
            end
          end else if (rd_last) begin
            out_gate <= 1'b0;
            req_done <= gnt_oh;
            state <= S_DONE;
          end
        S_DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(DRAIN_CYCLES - 1)) begin
            req_done <= gnt_oh;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          req_done <= '0;
          cntl_rw <= IDLE_RW;
          busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// tb_axis_bram_adapter_v1_0_sched: directed scoreboard bench for the adapter scheduler
module tb_axis_bram_adapter_v1_0_sched;
  localparam int L = 12, W = 36, N = 2, D = 2;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_rw = '0;
  logic [N*L-1:0] req_start = '0, req_bound = '0;
  logic [N-1:0] req_ready, req_done, req_err;
  logic busy, cntl_rw, cntl_addr_reload, in_gate, out_gate;
  logic [L-1:0] cntl_start_index, cntl_bound_index;
  logic s_in_valid = 0, s_in_accep = 1, s_out_valid = 0, s_out_accep = 0, s_out_tlast = 0;

  axis_bram_adapter_v1_0_sched #(.BRAM_ADDR_LENGTH(L), .BRAM_WIDTH_IN_WORD(W), .NUM_REQ(N), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw), .req_start(req_start),
    .req_bound(req_bound), .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .busy(busy), .cntl_rw(cntl_rw), .cntl_addr_reload(cntl_addr_reload),
    .cntl_start_index(cntl_start_index), .cntl_bound_index(cntl_bound_index),
    .in_gate(in_gate), .out_gate(out_gate), .s_in_valid(s_in_valid), .s_in_accep(s_in_accep),
    .s_out_valid(s_out_valid), .s_out_accep(s_out_accep), .s_out_tlast(s_out_tlast)
  );

  typedef struct packed {
    logic [1:0] rdy, err, done;
    logic reload, rw;
    logic [11:0] st, bd;
  } ev_t;
  ev_t q[$];
  int total = 0, bad = 0;
  int in_beats = 0, out_beats = 0, rd_total = 36;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // every pulse or reload the DUT shows must match the next queued expectation
  always @(negedge clk)
    if (!rst && (|req_ready || |req_err || |req_done || cntl_addr_reload)) begin
      ev_t a;
      a = '0;
      a.rdy = req_ready;
      a.err = req_err;
      a.done = req_done;
      a.reload = cntl_addr_reload;
      if (cntl_addr_reload) begin
        a.rw = cntl_rw;
        a.st = cntl_start_index;
        a.bd = cntl_bound_index;
      end
      if (q.size() == 0) chk("unexpected_event", a, 32'hffff_ffff);
      else chk("event", a, q.pop_front());
    end

  always @(negedge clk)
    if (cntl_addr_reload) begin
      in_beats <= 0;
      out_beats <= 0;
    end else begin
      if (s_in_valid && s_in_accep && in_gate) in_beats <= in_beats + 1;
      if (s_out_valid && s_out_accep && out_gate) out_beats <= out_beats + 1;
    end

  // stand-in for the adapter streams: random source gaps, random downstream stalls
  always @(posedge clk) begin
    #1;
    s_in_valid = in_gate && ($urandom_range(0, 3) != 0);
    s_out_valid = out_gate;
    s_out_accep = $urandom_range(0, 2) != 0;
    s_out_tlast = out_gate && (out_beats == rd_total - 1);
  end

  task automatic push_cmd(input int r, input logic rw, input int st, input int bd, input bit with_done);
    ev_t e;
    e = '0;
    e.rdy = 2'(1 << r);
    if (bd < st) e.err = 2'(1 << r);
    q.push_back(e);
    if (bd >= st) begin
      e = '0;
      e.reload = 1'b1;
      e.rw = rw;
      e.st = 12'(st);
      e.bd = 12'(bd);
      q.push_back(e);
      if (with_done) begin
        e = '0;
        e.done = 2'(1 << r);
        q.push_back(e);
      end
    end
  endtask

  task automatic post(input int r, input logic rw, input int st, input int bd, input string nm);
    int n;
    @(posedge clk);
    #1;
    req_valid[r] = 1'b1;
    req_rw[r] = rw;
    req_start[r*L +: L] = L'(st);
    req_bound[r*L +: L] = L'(bd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 20);
    chk({nm, "_grant"}, 32'(req_ready[r]), 1);
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    chk({nm, "_reload"}, 32'(cntl_addr_reload), 1);
  endtask

  task automatic run(input int r, input logic rw, input int st, input int bd, input string nm);
    int n, last_gate;
    rd_total = (bd - st + 1) * W;
    push_cmd(r, rw, st, bd, 1);
    post(r, rw, st, bd, nm);
    n = 0;
    last_gate = 0;
    while (!req_done[r] && n < 5000) begin
      @(negedge clk);
      n++;
      if (in_gate || out_gate) last_gate = n;
    end
    chk({nm, "_done"}, 32'(req_done[r]), 1);
    chk({nm, "_tail"}, n - last_gate, rw ? D + 1 : 1);
    chk({nm, "_beats"}, rw ? in_beats : out_beats, (bd - st + 1) * W);
    @(negedge clk);
    chk({nm, "_idle"}, {busy, cntl_rw}, 2'b01);
  endtask

  initial begin
    int n, g0, g1, d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rw", cntl_rw, 1);
    chk("rst_reload", cntl_addr_reload, 0);
    chk("rst_idx", {cntl_start_index, cntl_bound_index}, 0);
    chk("rst_gates", {in_gate, out_gate}, 0);
    chk("rst_pulses", {req_ready, req_done, req_err}, 0);
    @(posedge clk);
    #1;
    rst = 0;

    run(0, 1'b1, 3, 4, "wr0");
    run(1, 1'b0, 5, 5, "rd1");

    // reset during a write: no completion may follow
    rd_total = 72;
    push_cmd(0, 1'b1, 3, 4, 0);
    post(0, 1'b1, 3, 4, "mid");
    n = 0;
    while (in_beats < 10 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_progress", 32'(in_beats >= 10), 1);
    rst = 1;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_gates", {in_gate, out_gate}, 0);
    chk("mid_rw", cntl_rw, 1);
    chk("mid_done", req_done, 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (6) @(negedge clk);
    chk("mid_queue", q.size(), 0);

    // both requesters held valid: grants must alternate
    rd_total = 36;
    for (int k = 0; k < 4; k++) push_cmd(k % 2, k % 2 == 0, k % 2 ? 5 : 1, k % 2 ? 5 : 1, 1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    req_rw = 2'b01;
    req_start = {12'd5, 12'd1};
    req_bound = {12'd5, 12'd1};
    g0 = 0;
    g1 = 0;
    d = 0;
    n = 0;
    while (d < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      if (req_ready[0]) g0++;
      if (req_ready[1]) g1++;
      if (|req_done) d++;
      @(posedge clk);
      #1;
      if (g0 >= 2) req_valid[0] = 1'b0;
      if (g1 >= 2) req_valid[1] = 1'b0;
    end
    chk("alt_dones", d, 4);
    chk("alt_grants", {g0[15:0], g1[15:0]}, {16'd2, 16'd2});

    // bad command from req0 alongside a good one from req1
    push_cmd(0, 1'b1, 7, 6, 1);
    push_cmd(1, 1'b1, 2, 2, 1);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    req_rw = 2'b11;
    req_start = {12'd2, 12'd7};
    req_bound = {12'd2, 12'd6};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_err[0] && n < 20);
    chk("err_pulse", req_err, 2'b01);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("err_busy", {busy, cntl_addr_reload}, 0);
    chk("err_next_grant", req_ready, 2'b10);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    n = 0;
    while (!req_done[1] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("err_req1_done", req_done, 2'b10);
    chk("err_req1_beats", in_beats, 36);

    run(0, 1'b1, 4095, 4095, "top_row");

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
